// File: rtl/gpio_cond_pkg.sv
// Shared defaults and helpers for the GPIO input conditioner.
package gpio_cond_pkg;

  localparam int DEFAULT_WIDTH           = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Bits needed to hold 0..cycles, i.e. ceil(log2(cycles+1)), never below 1.
  function automatic int counterWidth(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One conditioned GPIO bit: two-flop synchroniser, debounce counter,
// accepted-level register and registered rise/fall pulses.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pinIn,
  input  logic bypass,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = counterWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] count;
  logic          stableNext;
  logic [CW-1:0] countNext;

  // Counter step that holds at LAST instead of wrapping.
  function automatic logic [CW-1:0] satIncrement(input logic [CW-1:0] c);
    return (c == LAST) ? LAST : c + CW'(1);
  endfunction

  // Next accepted level and qualification count from the synchronised sample.
  always_comb begin
    stableNext = stable;
    countNext  = '0;
    if (bypass) begin
      stableNext = sync2;
    end else if (sync2 != stable) begin
      if (count == LAST) begin
        stableNext = sync2;
      end else begin
        countNext = satIncrement(count);
      end
    end
  end

  // Synchroniser, accepted level, counter and edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1  <= pinIn;
      sync2  <= sync1;
      stable <= stableNext;
      count  <= countNext;
      rise   <= stableNext & ~stable;
      fall   <= ~stableNext & stable;
    end
  end

  assign level = stable;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions WIDTH raw GPIO pad inputs into clean, debounced levels with
// per-bit rise/fall pulses; each bit is an independent gpio_debounce_bit.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             io_clock,
  input  logic             io_reset,
  input  logic [WIDTH-1:0] io_pins_in,
  input  logic [WIDTH-1:0] io_bypass,
  output logic [WIDTH-1:0] io_pins_read,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall
);

  // One conditioner per pin; bits share nothing but clock and reset.
  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBit (
      .clk   (io_clock),
      .rst   (io_reset),
      .pinIn (io_pins_in[i]),
      .bypass(io_bypass[i]),
      .level (io_pins_read[i]),
      .rise  (io_rise[i]),
      .fall  (io_fall[i])
    );
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with WIDTH=5, DEBOUNCE_CYCLES=4.
module tb_gpio_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pins;
  logic [4:0] byp;
  logic [4:0] pinsRead;
  logic [4:0] rise;
  logic [4:0] fall;

  int passCount = 0;
  int totalCount = 0;

  typedef struct {
    logic       rst;
    logic [4:0] pins;
    logic [4:0] byp;
    logic [4:0] expRead;
    logic [4:0] expRise;
    logic [4:0] expFall;
  } vec_t;

  vec_t vecs[$];

  gpio_input_conditioner #(
    .WIDTH(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .io_clock    (clk),
    .io_reset    (rst),
    .io_pins_in  (pins),
    .io_bypass   (byp),
    .io_pins_read(pinsRead),
    .io_rise     (rise),
    .io_fall     (fall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checkAll(input string tag, input logic [4:0] eRead,
                          input logic [4:0] eRise, input logic [4:0] eFall);
    check({tag, " read"}, pinsRead, eRead);
    check({tag, " rise"}, rise, eRise);
    check({tag, " fall"}, fall, eFall);
  endtask

  task automatic addVec(input int n, input logic r, input logic [4:0] p, input logic [4:0] b,
                        input logic [4:0] eRead, input logic [4:0] eRise, input logic [4:0] eFall);
    vec_t v;
    v.rst = r; v.pins = p; v.byp = b;
    v.expRead = eRead; v.expRise = eRise; v.expFall = eFall;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    rst  = 1'b1;
    pins = 5'b0;
    byp  = 5'b0;

    // Reset, bit 0 rises, bits 3/4 rise together, bit 0 falls, bits 3/4 fall.
    addVec(2, 1'b1, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000);
    addVec(5, 1'b0, 5'b00001, 5'b0, 5'b00000, 5'b00000, 5'b00000);
    addVec(1, 1'b0, 5'b00001, 5'b0, 5'b00001, 5'b00001, 5'b00000);
    addVec(1, 1'b0, 5'b00001, 5'b0, 5'b00001, 5'b00000, 5'b00000);
    addVec(5, 1'b0, 5'b11001, 5'b0, 5'b00001, 5'b00000, 5'b00000);
    addVec(1, 1'b0, 5'b11001, 5'b0, 5'b11001, 5'b11000, 5'b00000);
    addVec(1, 1'b0, 5'b11001, 5'b0, 5'b11001, 5'b00000, 5'b00000);
    addVec(5, 1'b0, 5'b11000, 5'b0, 5'b11001, 5'b00000, 5'b00000);
    addVec(1, 1'b0, 5'b11000, 5'b0, 5'b11000, 5'b00000, 5'b00001);
    addVec(2, 1'b0, 5'b11000, 5'b0, 5'b11000, 5'b00000, 5'b00000);
    addVec(5, 1'b0, 5'b00000, 5'b0, 5'b11000, 5'b00000, 5'b00000);
    addVec(1, 1'b0, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b11000);
    addVec(1, 1'b0, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000);

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      pins = vecs[i].pins;
      byp  = vecs[i].byp;
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].expRead, vecs[i].expRise, vecs[i].expFall);
    end

    // Bit 1 glitch of 3 cycles is rejected.
    for (int k = 0; k < 10; k++) begin
      pins = (k < 3) ? 5'b00010 : 5'b00000;
      tick();
      checkAll($sformatf("glitch3 c%0d", k), 5'b00000, 5'b00000, 5'b00000);
    end

    // Bit 1 high for exactly 4 cycles is accepted, then falls after 4 low.
    for (int k = 0; k < 12; k++) begin
      pins = (k < 4) ? 5'b00010 : 5'b00000;
      tick();
      checkAll($sformatf("pulse4 c%0d", k),
               (k >= 5 && k <= 8) ? 5'b00010 : 5'b00000,
               (k == 5) ? 5'b00010 : 5'b00000,
               (k == 9) ? 5'b00010 : 5'b00000);
    end

    // Bypassed bit 2: one-cycle high passes through two edges later.
    byp = 5'b00100;
    for (int k = 0; k < 6; k++) begin
      pins = (k == 0) ? 5'b00100 : 5'b00000;
      tick();
      checkAll($sformatf("bypass c%0d", k),
               (k == 2) ? 5'b00100 : 5'b00000,
               (k == 2) ? 5'b00100 : 5'b00000,
               (k == 3) ? 5'b00100 : 5'b00000);
    end

    // Bypass accepts a high, then is removed while high: no extra pulse,
    // and the later fall goes through normal debouncing.
    pins = 5'b00100;
    for (int k = 0; k < 6; k++) begin
      byp = (k < 3) ? 5'b00100 : 5'b00000;
      tick();
      checkAll($sformatf("bypOff c%0d", k),
               (k >= 2) ? 5'b00100 : 5'b00000,
               (k == 2) ? 5'b00100 : 5'b00000,
               5'b00000);
    end
    pins = 5'b00000;
    for (int k = 0; k < 7; k++) begin
      tick();
      checkAll($sformatf("bypFall c%0d", k),
               (k <= 4) ? 5'b00100 : 5'b00000,
               5'b00000,
               (k == 5) ? 5'b00100 : 5'b00000);
    end

    // Reset in the middle of qualification discards it; held pin rises later.
    pins = 5'b00001;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkAll($sformatf("preRst c%0d", k), 5'b00000, 5'b00000, 5'b00000);
    end
    rst = 1'b1;
    tick();
    checkAll("midRst", 5'b00000, 5'b00000, 5'b00000);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      checkAll($sformatf("postRst c%0d", k),
               (k >= 5) ? 5'b00001 : 5'b00000,
               (k == 5) ? 5'b00001 : 5'b00000,
               5'b00000);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
